serial_add_unit: RTL and testbench
==================================

Name: serial_add_unit

Overview:
- Parametrised multi-cycle add/subtract unit. Successor to the single-bit combinational half adder.
- Operates on WIDTH-bit operands and processes DIGIT bits per clock, LSB first, through a registered carry.
- Supports add and two's-complement subtract, with carry-out and signed-overflow flags.
- Sits behind the tile's user I/O: valid/ready on both the operand side and the result side. Interfaces to the tt_um top-level wrapper.

Parameters:
- WIDTH, 8, operand and result width in bits. Must be ≥2.
- DIGIT, 1, bits processed per cycle. Must divide WIDTH exactly. N = WIDTH/DIGIT beats per operation.

Ports:
- clk  in  1  clock. The block has exactly one clock.
- rst  in  1  reset; synchronous and active-high, sampled on the rising edge of clk.
- in_valid  in  1  operands a, b, sub are valid.
- in_ready  out  1  block can accept operands this cycle.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- sub  in  1  1 = compute a-b; 0 = compute a+b.
- out_valid  out  1  sum, cout and ovf are valid.
- out_ready  in  1  consumer takes the result this cycle.
- sum  out  WIDTH  result modulo 2^WIDTH.
- cout  out  1  carry out of the MSB. For subtract, 1 = no borrow.
- ovf  out  1  signed overflow: carry into MSB XOR carry out of MSB.
- busy  out  1  high in RUN state.

Behaviour:
- Reset (rst=1 at a clk edge):
  - state=IDLE.
  - All shift registers, carry, count, sum, cout and ovf are 0.
  - out_valid=0, busy=0.
  - Reset mid-RUN or mid-DONE aborts the operation; no result is ever emitted for it.
- States: IDLE, RUN, DONE.
- in_ready = (state==IDLE) | (state==DONE & out_ready). It is combinational from state and out_ready.
- Accept happens when in_valid & in_ready at an edge. On accept:
  - opA <= a; opB <= sub ? ~b : b.
  - carry <= sub; count <= 0; state <= RUN.
- RUN, each cycle:
  - The digit adder adds opA[DIGIT-1:0], opB[DIGIT-1:0] and carry.
  - opA and opB shift right by DIGIT.
  - The DIGIT result bits shift into sum from the MSB end.
  - carry <= digit carry-out; count++.
  - On the last beat (count==N-1):
    - Capture cout from the digit carry-out.
    - Capture ovf from (carry into the MSB position) XOR (carry out of the MSB position).
    - Go to DONE.
- Latency: out_valid rises exactly N cycles after the accepting edge.
  - WIDTH=8, DIGIT=1 gives 8 cycles.
  - WIDTH=8, DIGIT=8 gives 1 cycle.
- DONE:
  - out_valid=1; sum, cout and ovf are held stable while out_ready=0, for any number of cycles.
  - On out_ready=1 with no accept: state goes to IDLE and out_valid falls at the next edge.
  - On out_ready=1 and in_valid=1 in the same cycle: the result is consumed and the new operands are accepted at the same edge, going directly to RUN. There is no idle bubble.
- sum, cout and ovf are meaningful only when out_valid=1. sum shifts internally during RUN.
- in_valid during RUN is ignored (in_ready=0). Operands are not captured and must be held by the producer.
- Arithmetic wraps modulo 2^WIDTH. No saturation.

Decomposition:
- Shared package serial_add_pkg holds:
  - state enum {IDLE, RUN, DONE};
  - function beats(WIDTH, DIGIT);
  - count width constant CNT_W = max(1, clog2(N)).
- One sub-module: serial_add_digit. It is a combinational DIGIT-bit ripple of full adders.
  - Inputs: x, y, cin.
  - Outputs: s, cout, and c_msb_in (carry into its top bit, used for ovf).
- Top level holds the FSM, shift registers and the handshake.

Test Plan:
- WIDTH=8, DIGIT=1, add 0x35+0x4A:
  - sum=0x7F, cout=0, ovf=0.
  - out_valid 8 cycles after accept.
  - busy high for exactly 8 cycles.
- Add 0x7F+0x01 -> sum=0x80, cout=0, ovf=1. Add 0xFF+0x01 -> sum=0x00, cout=1, ovf=0.
- Subtract 0x10-0x20 -> sum=0xF0, cout=0, ovf=0. Subtract 0x80-0x01 -> sum=0x7F, cout=1, ovf=1.
- Backpressure and back-to-back:
  - Hold out_ready=0 for 5 cycles in DONE; sum must stay stable and in_ready=0.
  - Then assert out_ready and in_valid together with 0x01+0x02.
  - Required: immediate RUN, then result 0x03 8 cycles later.
- Reset mid-RUN:
  - Assert rst at beat 4.
  - Required next cycle: out_valid=0, sum=0, in_ready=1.
  - The next operation 0x22+0x11 gives 0x33.
- Parameter sweep with DIGIT ∈ {1,2,4,8} at WIDTH=8, plus WIDTH=16/DIGIT=4:
  - Run 1000 random operands against a reference model.
  - Check latency = WIDTH/DIGIT for every operation.

Source files
------------

// File: rtl/serial_add_pkg.sv
// Shared types and sizing helpers for the digit-serial add/subtract unit.
// Imported by the digit adder and the top-level sequencer.
package serial_add_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic int beats(input int width, input int digit);
        return width / digit;
    endfunction

    // Beat counter width; a single-beat unit still keeps one counter bit.
    function automatic int cnt_w(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/serial_add_digit.sv
// Combinational DIGIT-bit ripple of full adders.
// Also exposes the carry into its top bit for signed-overflow detection.
module serial_add_digit
    import serial_add_pkg::*;
#(
    parameter int DIGIT = 1
) (
    input  logic [DIGIT-1:0] x,
    input  logic [DIGIT-1:0] y,
    input  logic             cin,
    output logic [DIGIT-1:0] s,
    output logic             cout,
    output logic             c_msb_in
);

    logic c;

    always_comb begin
        c        = cin;
        s        = '0;
        c_msb_in = cin;
        for (int i = 0; i < DIGIT; i++) begin
            c_msb_in = c;
            s[i]     = x[i] ^ y[i] ^ c;
            c        = (x[i] & y[i]) | (c & (x[i] ^ y[i]));
        end
        cout = c;
    end

endmodule

// File: rtl/serial_add_unit.sv
// Multi-cycle add/subtract: DIGIT bits per clock, LSB first,
// with valid/ready handshakes on both operand and result sides.
module serial_add_unit
    import serial_add_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             busy
);

    localparam int N     = beats(WIDTH, DIGIT);
    localparam int CNT_W = cnt_w(N);

    generate
        if (WIDTH < 2 || DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_bad_params
            $error("serial_add_unit: WIDTH must be >= 2 and a multiple of DIGIT");
        end
    endgenerate

    state_t state;
    state_t state_next;

    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic [WIDTH-1:0] sum_q;
    logic             carry;
    logic [CNT_W-1:0] count;
    logic             cout_q;
    logic             ovf_q;

    logic [DIGIT-1:0] d_s;
    logic             d_cout;
    logic             d_cmsb;
    logic             accept;
    logic             last;

    logic [WIDTH+DIGIT-1:0] sum_cat;

    assign accept  = in_valid & in_ready;
    assign last    = (count == CNT_W'(N - 1));
    assign sum_cat = {d_s, sum_q};

    serial_add_digit #(
        .DIGIT(DIGIT)
    ) u_digit (
        .x       (op_a[DIGIT-1:0]),
        .y       (op_b[DIGIT-1:0]),
        .cin     (carry),
        .s       (d_s),
        .cout    (d_cout),
        .c_msb_in(d_cmsb)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: begin
                if (in_valid) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                if (last) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_next = in_valid ? RUN : IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state == IDLE) | ((state == DONE) & out_ready);
        out_valid = (state == DONE);
        busy      = (state == RUN);
    end

    // Subtract is a + ~b + 1: the +1 rides in as the initial carry.
    always_ff @(posedge clk) begin
        if (rst) begin
            op_a   <= '0;
            op_b   <= '0;
            sum_q  <= '0;
            carry  <= 1'b0;
            count  <= '0;
            cout_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else if (accept) begin
            op_a  <= a;
            op_b  <= sub ? ~b : b;
            carry <= sub;
            count <= '0;
        end else if (state == RUN) begin
            op_a  <= op_a >> DIGIT;
            op_b  <= op_b >> DIGIT;
            sum_q <= sum_cat[WIDTH+DIGIT-1:DIGIT];
            carry <= d_cout;
            count <= count + CNT_W'(1);
            if (last) begin
                cout_q <= d_cout;
                ovf_q  <= d_cmsb ^ d_cout;
            end
        end
    end

    assign sum  = sum_q;
    assign cout = cout_q;
    assign ovf  = ovf_q;

endmodule

// File: tb/tb_serial_add_unit.sv
// Directed and swept checks for serial_add_unit.
// Main instance is WIDTH=8/DIGIT=1; five more cover the parameter sweep.
module tb_serial_add_unit;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] a = '0;
    logic [7:0] b = '0;
    logic       sub = 1'b0;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [7:0] sum;
    logic       cout;
    logic       ovf;
    logic       busy;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    serial_add_unit #(
        .WIDTH(8),
        .DIGIT(1)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .a        (a),
        .b        (b),
        .sub      (sub),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .sum      (sum),
        .cout     (cout),
        .ovf      (ovf),
        .busy     (busy)
    );

    logic [15:0]      sw_a = '0;
    logic [15:0]      sw_b = '0;
    logic             sw_sub = 1'b0;
    logic             sw_valid = 1'b0;
    logic [15:0]      sw_sum [5];
    logic [4:0]       sw_ov;
    logic [4:0]       sw_cout;
    logic [4:0]       sw_ovf;
    logic [4:0]       sw_ir;
    logic [4:0]       sw_busy;

    for (genvar g = 0; g < 5; g++) begin : g_sw
        localparam int W = (g == 4) ? 16 : 8;
        localparam int D = (g == 0) ? 1 : (g == 1) ? 2 :
                           (g == 2) ? 4 : (g == 3) ? 8 : 4;
        logic [W-1:0] s;
        serial_add_unit #(
            .WIDTH(W),
            .DIGIT(D)
        ) u (
            .clk      (clk),
            .rst      (rst),
            .in_valid (sw_valid),
            .in_ready (sw_ir[g]),
            .a        (sw_a[W-1:0]),
            .b        (sw_b[W-1:0]),
            .sub      (sw_sub),
            .out_valid(sw_ov[g]),
            .out_ready(1'b1),
            .sum      (s),
            .cout     (sw_cout[g]),
            .ovf      (sw_ovf[g]),
            .busy     (sw_busy[g])
        );
        assign sw_sum[g] = 16'(s);
    end

    // Launch one operation on the main DUT and wait for its result.
    task automatic run_op(input logic [7:0] xa, input logic [7:0] xb,
                          input logic xs, output int lat, output int bc);
        a        = xa;
        b        = xb;
        sub      = xs;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        lat = 0;
        bc  = 0;
        while (lat < 40 && !out_valid) begin
            if (busy) bc++;
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic consume();
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_flags: out_valid=%b busy=%b in_ready=%b want 0 0 1",
                     out_valid, busy, in_ready);
        end
        checks++;
        if (sum !== 8'h00 || cout !== 1'b0 || ovf !== 1'b0) begin
            errors++;
            $display("FAIL reset_result: sum=%h cout=%b ovf=%b want 00 0 0",
                     sum, cout, ovf);
        end
    endtask

    task automatic test_add();
        int lat, bc;
        run_op(8'h35, 8'h4A, 1'b0, lat, bc);
        checks++;
        if (lat !== 8) begin
            errors++;
            $display("FAIL add_latency: got %0d want 8", lat);
        end
        checks++;
        if (bc !== 8) begin
            errors++;
            $display("FAIL add_busy_cycles: got %0d want 8", bc);
        end
        checks++;
        if (sum !== 8'h7F || cout !== 1'b0 || ovf !== 1'b0) begin
            errors++;
            $display("FAIL add_35_4a: sum=%h cout=%b ovf=%b want 7f 0 0", sum, cout, ovf);
        end
        consume();
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL add_consume: out_valid=%b in_ready=%b want 0 1", out_valid, in_ready);
        end
    endtask

    task automatic test_overflow();
        int lat, bc;
        run_op(8'h7F, 8'h01, 1'b0, lat, bc);
        checks++;
        if (sum !== 8'h80 || cout !== 1'b0 || ovf !== 1'b1) begin
            errors++;
            $display("FAIL add_7f_01: sum=%h cout=%b ovf=%b want 80 0 1", sum, cout, ovf);
        end
        consume();
        run_op(8'hFF, 8'h01, 1'b0, lat, bc);
        checks++;
        if (sum !== 8'h00 || cout !== 1'b1 || ovf !== 1'b0) begin
            errors++;
            $display("FAIL add_ff_01: sum=%h cout=%b ovf=%b want 00 1 0", sum, cout, ovf);
        end
        consume();
    endtask

    task automatic test_subtract();
        int lat, bc;
        run_op(8'h10, 8'h20, 1'b1, lat, bc);
        checks++;
        if (sum !== 8'hF0 || cout !== 1'b0 || ovf !== 1'b0) begin
            errors++;
            $display("FAIL sub_10_20: sum=%h cout=%b ovf=%b want f0 0 0", sum, cout, ovf);
        end
        consume();
        run_op(8'h80, 8'h01, 1'b1, lat, bc);
        checks++;
        if (lat !== 8) begin
            errors++;
            $display("FAIL sub_latency: got %0d want 8", lat);
        end
        checks++;
        if (sum !== 8'h7F || cout !== 1'b1 || ovf !== 1'b1) begin
            errors++;
            $display("FAIL sub_80_01: sum=%h cout=%b ovf=%b want 7f 1 1", sum, cout, ovf);
        end
        consume();
    endtask

    task automatic test_back_to_back();
        int lat, bc;
        run_op(8'hA0, 8'h05, 1'b0, lat, bc);
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (out_valid !== 1'b1 || sum !== 8'hA5 || in_ready !== 1'b0 || busy !== 1'b0) begin
                errors++;
                $display("FAIL hold_%0d: out_valid=%b sum=%h in_ready=%b busy=%b want 1 a5 0 0",
                         i, out_valid, sum, in_ready, busy);
            end
            @(posedge clk);
            #1;
        end
        a         = 8'h01;
        b         = 8'h02;
        sub       = 1'b0;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL b2b_in_ready: got %b want 1", in_ready);
        end
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        checks++;
        if (busy !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL b2b_no_bubble: busy=%b out_valid=%b want 1 0", busy, out_valid);
        end
        lat = 0;
        while (lat < 40 && !out_valid) begin
            @(posedge clk);
            #1;
            lat++;
        end
        checks++;
        if (lat !== 8) begin
            errors++;
            $display("FAIL b2b_latency: got %0d want 8", lat);
        end
        checks++;
        if (sum !== 8'h03 || cout !== 1'b0 || ovf !== 1'b0) begin
            errors++;
            $display("FAIL b2b_result: sum=%h cout=%b ovf=%b want 03 0 0", sum, cout, ovf);
        end
        consume();
    endtask

    task automatic test_reset_mid_run();
        int lat, bc;
        a        = 8'hC3;
        b        = 8'h3C;
        sub      = 1'b0;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || sum !== 8'h00 || in_ready !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_run: out_valid=%b sum=%h in_ready=%b busy=%b want 0 00 1 0",
                     out_valid, sum, in_ready, busy);
        end
        repeat (10) @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL rst_no_result: out_valid=%b want 0", out_valid);
        end
        run_op(8'h22, 8'h11, 1'b0, lat, bc);
        checks++;
        if (sum !== 8'h33 || lat !== 8) begin
            errors++;
            $display("FAIL rst_next_op: sum=%h lat=%0d want 33 8", sum, lat);
        end
        consume();
    endtask

    task automatic test_sweep();
        logic [15:0] es [5];
        logic [4:0]  ec;
        logic [4:0]  eo;
        logic [4:0]  seen;
        int          nb [5];
        for (int op = 0; op < 1000; op++) begin
            sw_a   = 16'($urandom);
            sw_b   = 16'($urandom);
            sw_sub = 1'($urandom_range(0, 1));
            for (int g = 0; g < 5; g++) begin
                int          w;
                int          d;
                logic [16:0] mask;
                logic [16:0] ma;
                logic [16:0] mb;
                logic [16:0] full;
                w     = (g == 4) ? 16 : 8;
                d     = (g == 0) ? 1 : (g == 1) ? 2 : (g == 2) ? 4 : (g == 3) ? 8 : 4;
                nb[g] = w / d;
                mask  = (17'd1 << w) - 17'd1;
                ma    = {1'b0, sw_a} & mask;
                mb    = {1'b0, sw_b} & mask;
                if (sw_sub) mb = ~mb & mask;
                full  = ma + mb + 17'(sw_sub);
                es[g] = 16'(full & mask);
                ec[g] = full[w];
                eo[g] = (ma[w-1] == mb[w-1]) && (full[w-1] != ma[w-1]);
            end
            sw_valid = 1'b1;
            @(posedge clk);
            #1;
            sw_valid = 1'b0;
            seen = '0;
            for (int k = 1; k <= 18; k++) begin
                @(posedge clk);
                #1;
                for (int g = 0; g < 5; g++) begin
                    if (!seen[g] && sw_ov[g]) begin
                        seen[g] = 1'b1;
                        checks++;
                        if (k != nb[g]) begin
                            errors++;
                            $display("FAIL sweep_lat g%0d op%0d: got %0d want %0d",
                                     g, op, k, nb[g]);
                        end
                        checks++;
                        if (sw_sum[g] !== es[g] || sw_cout[g] !== ec[g] || sw_ovf[g] !== eo[g]) begin
                            errors++;
                            $display("FAIL sweep_res g%0d op%0d a=%h b=%h sub=%b: sum=%h c=%b v=%b want %h %b %b",
                                     g, op, sw_a, sw_b, sw_sub, sw_sum[g], sw_cout[g],
                                     sw_ovf[g], es[g], ec[g], eo[g]);
                        end
                    end
                end
            end
            for (int g = 0; g < 5; g++) begin
                if (!seen[g]) begin
                    checks++;
                    errors++;
                    $display("FAIL sweep_timeout g%0d op%0d: no out_valid within 18 cycles", g, op);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_overflow();
        test_subtract();
        test_back_to_back();
        test_reset_mid_run();
        test_sweep();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
